misc_wb_queue: RTL and testbench

- Result buffer directly downstream of the 64/128-bit misc/convert unit (BSWAP, NEG, DAA/DAS, POS, CFZ/CFN, LOOP).
- Captures each completed result: 128-bit value, 3-bit size code SR, flags ZERO/SIGN/OVR/COUT/NaN, 4-bit destination tag.
- Holds results in a small FIFO until the register-file write-back arbiter grants the port.
- Decouples the fixed-latency misc unit from write-back contention and provides issue back-pressure.

---
 rtl/misc_wbq_pkg.sv | 33 +++
 rtl/misc_wbq_mem.sv | 38 +++
 rtl/misc_wb_queue.sv | 145 ++++++++++++++
 tb/tb_misc_wb_queue.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/misc_wbq_pkg.sv
// misc_wbq_pkg
//   Shared types and constants for the misc/convert result write-back queue.
//   misc_result_t is one queue entry: destination tag, size code, flags and
//   the result value. The flag index and size-code constants name the fields
//   that the misc unit produces. The queue stores these fields without
//   interpreting them.
package misc_wbq_pkg;

  localparam int MISC_DW = 128;
  localparam int MISC_TW = 4;

  // Bit positions inside the 5-bit flag vector {NaN, COUT, OVR, SIGN, ZERO}
  localparam int FLG_ZERO = 0;
  localparam int FLG_SIGN = 1;
  localparam int FLG_OVR  = 2;
  localparam int FLG_COUT = 3;
  localparam int FLG_NAN  = 4;

  // Result size codes carried on SR
  localparam logic [2:0] SR_B = 3'd0;
  localparam logic [2:0] SR_W = 3'd1;
  localparam logic [2:0] SR_D = 3'd2;
  localparam logic [2:0] SR_Q = 3'd3;
  localparam logic [2:0] SR_O = 3'd4;

  typedef struct packed {
    logic [MISC_TW-1:0] dst;
    logic [2:0]         sr;
    logic [4:0]         flg;
    logic [MISC_DW-1:0] r;
  } misc_result_t;

endpackage

// File: rtl/misc_wbq_mem.sv
// misc_wbq_mem
//   Entry storage for the write-back queue. It is a DEPTH x misc_result_t
//   register array with one synchronous write port and one asynchronous read
//   port. Because the read port is asynchronous, the head entry appears on the
//   output with no read latency.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write slot
//   wdata  in  entry to store
//   raddr  in  read slot (queue head)
//   rdata  out entry at raddr
// The storage has no reset. Slots are only read after they have been written.
module misc_wbq_mem
  import misc_wbq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  misc_result_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output misc_result_t             rdata
);

  misc_result_t mem [DEPTH];

  // Single write port. This is plain storage, so there is no reset here.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/misc_wb_queue.sv
// misc_wb_queue
//   Show-ahead result FIFO between the misc/convert unit and the register-file
//   write-back arbiter. It absorbs write-back contention and raises STALL to
//   hold off misc issue before the queue can overflow.
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   VI, DSTi, SRi, Ri,  incoming result (valid, tag, size, value, flags)
//   FLGi
//   STALL               issue hold, decoded from the registered count only
//   WBV, WBDST, WBSR,   head entry toward write-back; the fields read as zero
//   WBR, WBFLG          while WBV is low
//   WBACK               write-back accepted; pops the head
//   CNT                 occupancy
//   OVF                 sticky overflow: a result arrived while the queue was
//                       full and nothing was popped
// Build option:
//   MISC_WBQ_BYPASS_EN  when this macro is defined, a result arriving at an
//                       empty queue is shown on the WB outputs in the same
//                       cycle. If WBACK is high in that cycle, the result is
//                       consumed without being stored.
module misc_wb_queue
  import misc_wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = MISC_DW,
  parameter int TW    = MISC_TW
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       VI,
  input  logic [TW-1:0]              DSTi,
  input  logic [2:0]                 SRi,
  input  logic [DW-1:0]              Ri,
  input  logic [4:0]                 FLGi,
  output logic                       STALL,
  output logic                       WBV,
  output logic [TW-1:0]              WBDST,
  output logic [2:0]                 WBSR,
  output logic [DW-1:0]              WBR,
  output logic [4:0]                 WBFLG,
  input  logic                       WBACK,
  output logic [$clog2(DEPTH+1)-1:0] CNT,
  output logic                       OVF
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic          empty;
  logic          full;
  logic          bypass;
  logic          wbv;
  logic          push;
  logic          pop;
  logic          mem_we;

  misc_result_t  in_ent;
  misc_result_t  mem_head;
  misc_result_t  head;

  assign in_ent = '{dst: DSTi, sr: SRi, flg: FLGi, r: Ri};

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

`ifdef MISC_WBQ_BYPASS_EN
  assign bypass = empty & VI;
  assign head   = bypass ? in_ent : mem_head;
`else
  assign bypass = 1'b0;
  assign head   = mem_head;
`endif

  assign wbv  = ~empty | bypass;
  assign pop  = WBACK & wbv;
  // When the queue is full, an incoming result is accepted only if the head
  // leaves in the same cycle.
  assign push = VI & (~full | pop);
  // A bypassed result that is accepted at once is never written to storage.
  // Both pointers still advance, so the pointers stay equal.
  assign mem_we = push & ~(bypass & pop);

  misc_wbq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (in_ent),
    .raddr (rd_ptr),
    .rdata (mem_head)
  );

  // Pointer, occupancy and overflow state. DEPTH is a power of two, so the
  // pointers wrap naturally. The count can never pass DEPTH because a push
  // into a full queue needs a pop in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
      if (VI && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

  // STALL is raised one slot early, because one result may already be in
  // flight when issue stops.
  assign STALL = (cnt >= CW'(DEPTH-1));
  assign CNT   = cnt;
  assign OVF   = ovf;
  assign WBV   = wbv;

  // The head fields are masked to zero whenever no valid entry is presented.
  always_comb begin
    WBDST = '0;
    WBSR  = '0;
    WBR   = '0;
    WBFLG = '0;
    if (wbv) begin
      WBDST = head.dst;
      WBSR  = head.sr;
      WBR   = head.r;
      WBFLG = head.flg;
    end
  end

endmodule

// File: tb/tb_misc_wb_queue.sv
// tb_misc_wb_queue
//   Scoreboard bench for misc_wb_queue. Every driven result that the queue
//   should accept is pushed to an expected-entry queue. Each cycle, the WB
//   outputs are compared against the front of that queue, and the entry is
//   popped when the write-back accept takes it.
module tb_misc_wb_queue;
  import misc_wbq_pkg::*;

  localparam int DEPTH = 4;
`ifdef MISC_WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RESET;
  logic         VI;
  logic [3:0]   DSTi;
  logic [2:0]   SRi;
  logic [127:0] Ri;
  logic [4:0]   FLGi;
  logic         STALL;
  logic         WBV;
  logic [3:0]   WBDST;
  logic [2:0]   WBSR;
  logic [127:0] WBR;
  logic [4:0]   WBFLG;
  logic         WBACK;
  logic [2:0]   CNT;
  logic         OVF;

  int total_checks = 0;
  int bad_checks   = 0;

  misc_result_t sb_q[$];
  bit           sb_ovf;

  misc_wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .VI    (VI),
    .DSTi  (DSTi),
    .SRi   (SRi),
    .Ri    (Ri),
    .FLGi  (FLGi),
    .STALL (STALL),
    .WBV   (WBV),
    .WBDST (WBDST),
    .WBSR  (WBSR),
    .WBR   (WBR),
    .WBFLG (WBFLG),
    .WBACK (WBACK),
    .CNT   (CNT),
    .OVF   (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // This task drives one cycle of inputs and checks the outputs at the falling
  // edge against the model. After the rising edge, it updates the model.
  task automatic applyStimulus(input logic vi, input logic [3:0] dst, input logic [2:0] sr,
                               input logic [127:0] r, input logic [4:0] flg, input logic wback);
    misc_result_t in_e;
    misc_result_t exp_head;
    bit exp_wbv;
    bit do_pop;
    bit do_push;
    int n;
    RESET = 1'b0;
    VI    = vi;
    DSTi  = dst;
    SRi   = sr;
    Ri    = r;
    FLGi  = flg;
    WBACK = wback;
    in_e  = '{dst: dst, sr: sr, flg: flg, r: r};
    @(negedge CLK);
    n = sb_q.size();
    exp_wbv  = (n != 0) || (BYP && vi);
    exp_head = '0;
    if (n != 0) exp_head = sb_q[0];
    else if (exp_wbv) exp_head = in_e;
    checkOutput("wbv",   256'(WBV),   256'(exp_wbv));
    checkOutput("head",  256'({WBDST, WBSR, WBFLG, WBR}), 256'(exp_head));
    checkOutput("cnt",   256'(CNT),   256'(n));
    checkOutput("stall", 256'(STALL), 256'(n >= DEPTH-1));
    checkOutput("ovf",   256'(OVF),   256'(sb_ovf));
    do_pop  = wback && exp_wbv;
    do_push = vi && (n < DEPTH || do_pop);
    if (vi && n == DEPTH && !do_pop) sb_ovf = 1'b1;
    @(posedge CLK);
    #1;
    if (do_pop && n != 0) void'(sb_q.pop_front());
    if (do_push && !(do_pop && n == 0)) sb_q.push_back(in_e);
  endtask

  task automatic applyReset(input logic vi);
    RESET = 1'b1;
    VI    = vi;
    WBACK = 1'b1;
    DSTi  = 4'hF;
    SRi   = SR_O;
    Ri    = 128'hDEAD;
    FLGi  = 5'h1F;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    VI    = 1'b0;
    WBACK = 1'b0;
    sb_q.delete();
    sb_ovf = 1'b0;
    checkOutput("rst_cnt",    256'(CNT), 256'(0));
    checkOutput("rst_wbv",    256'(WBV), 256'(0));
    checkOutput("rst_fields", 256'({WBDST, WBSR, WBFLG, WBR}), 256'(0));
    checkOutput("rst_ovf",    256'(OVF), 256'(0));
    checkOutput("rst_stall",  256'(STALL), 256'(0));
  endtask

  initial begin
    RESET = 1'b1;
    VI    = 1'b0;
    WBACK = 1'b0;
    DSTi  = '0;
    SRi   = '0;
    Ri    = '0;
    FLGi  = '0;
    sb_ovf = 1'b0;
    @(posedge CLK);
    applyReset(1'b0);

    // Three results in, then drain them back-to-back
    applyStimulus(1'b1, 4'd1, SR_B, 128'h11, 5'b00001, 1'b0);
    applyStimulus(1'b1, 4'd2, SR_W, 128'h22, 5'b00010, 1'b0);
    applyStimulus(1'b1, 4'd3, SR_D, 128'h33, 5'b00100, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'd0, SR_B, 128'h0, 5'b0, 1'b1);

    // Fill to the top, then overflow with a fifth result
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 4'(4 + i), SR_Q, 128'(32'h40 + i), 5'b01000, 1'b0);
    applyStimulus(1'b1, 4'd8, SR_O, 128'h88, 5'b10000, 1'b0);
    applyStimulus(1'b0, 4'd0, SR_B, 128'h0, 5'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'd0, SR_B, 128'h0, 5'b0, 1'b1);

    // Full queue with a push and a pop in the same cycle
    applyReset(1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 4'(10 + i), SR_D, 128'(32'hA0 + i), 5'b00011, 1'b0);
    applyStimulus(1'b1, 4'd9, SR_Q, 128'h99, 5'b00101, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'd0, SR_B, 128'h0, 5'b0, 1'b1);

    // Reset while holding two entries and with a result arriving
    applyStimulus(1'b1, 4'd1, SR_B, 128'h1, 5'b0, 1'b0);
    applyStimulus(1'b1, 4'd2, SR_B, 128'h2, 5'b0, 1'b0);
    applyReset(1'b1);

    // Write-back accepts while empty must not disturb anything
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'd0, SR_B, 128'h0, 5'b0, 1'(i % 2 == 0));

    // Result arriving at an empty queue with an immediate accept
    applyStimulus(1'b1, 4'd5, SR_B, 128'hAB, 5'b00001, 1'b1);
    applyStimulus(1'b0, 4'd0, SR_B, 128'h0, 5'b0, 1'b1);
    applyStimulus(1'b0, 4'd0, SR_B, 128'h0, 5'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 80; i++)
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 3'($urandom_range(0, 4)),
                    {$urandom, $urandom, $urandom, $urandom}, 5'($urandom),
                    1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'd0, SR_B, 128'h0, 5'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
